// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: one-outstanding fetch requester feeding a small
// prefetch FIFO of {instr, pc, pc+4}, flushed by CPU redirects.
module ifetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pc_plus4,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_SQUASH} state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_q [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc4_q   [DEPTH];
  logic             credit_ok, req_fire, push, pop;

  // Only FETCH can issue, and nothing is outstanding there, so the credit
  // check reduces to free space in the FIFO.
  assign credit_ok = (state_q == S_FETCH) && (count_q < CNT_W'(DEPTH));

  always_comb begin
    imem_req_valid = !rst && credit_ok && !redirect_valid;
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    out_valid      = (count_q != '0) && !redirect_valid;
    pop            = out_valid && out_ready;
    push           = (state_q == S_WAIT) && imem_rsp_valid && !redirect_valid;
    out_instr      = instr_q[rd_ptr_q];
    out_pc         = pc_q[rd_ptr_q];
    out_pc_plus4   = pc4_q[rd_ptr_q];
    count          = count_q;

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      // A response still in flight must be swallowed before fetching again.
      case (state_q)
        S_WAIT, S_SQUASH: state_d = imem_rsp_valid ? S_FETCH : S_SQUASH;
        default:          state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: if (req_fire) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_WAIT;
        end
        S_WAIT:   if (imem_rsp_valid) state_d = S_FETCH;
        S_SQUASH: if (imem_rsp_valid) state_d = S_FETCH;
        default:  state_d = S_FETCH;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC & ~32'h3;
      req_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is cleared on reset so an empty FIFO reads as zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        pc4_q[i]   <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= imem_rsp_data;
      pc_q[wr_ptr_q]    <= req_pc_q;
      pc4_q[wr_ptr_q]   <= req_pc_q + 32'd4;
    end
  end
endmodule
